// File: rtl/fig_06_alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions, buffer
// state encoding and the packed layout of a buffered adder result.
package fig_06_alu_result_stage_pkg;

  localparam int FLAG_S  = 3;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_CY = 1;
  localparam int FLAG_OV = 0;
  localparam int FLAG_N  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Entry layout, LSB first: dest[ADDR_W], wb_en, flag_we[4], ov, cy, z[DATA_W].
  // Offsets below are relative to the top of the dest field.
  localparam int ENT_WB_EN_OFS = 0;
  localparam int ENT_WE_OFS    = 1;
  localparam int ENT_OV_OFS    = 5;
  localparam int ENT_CY_OFS    = 6;
  localparam int ENT_Z_OFS     = 7;
  localparam int ENT_META_W    = 7;

  function automatic int ent_width(input int data_w, input int addr_w);
    return data_w + addr_w + ENT_META_W;
  endfunction

endpackage

// File: rtl/fig_06_alu_result_stage_buffer.sv
// Two-entry in-order result buffer; head is the oldest entry and the younger
// entry shifts into the head slot when the head retires.
module fig_06_alu_result_buffer
  import fig_06_alu_result_stage_pkg::*;
#(
  parameter int ENT_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [ENT_W-1:0] push_ent,
  output logic [ENT_W-1:0] head,
  output logic [ENT_W-1:0] tail,
  output logic [1:0]       occ
);

  state_t state;

  assign occ = state;

  // push is never asserted in FULL: the top withholds in_ready there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= push_ent;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= push_ent;
          end else if (push) begin
            tail  <= push_ent;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fig_06_alu_result_stage.sv
// ALU result stage: buffers adder results, writes them back in order and
// commits S/Z/CY/OV at retire. Define FIG06_ALU_RESULT_FLAG_FWD_EN to expose
// the post-drain (forwarded) flag view instead of the retired flags.
module fig_06_alu_result_stage
  import fig_06_alu_result_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_z,
  input  logic              in_cy,
  input  logic              in_ov,
  input  logic [3:0]        in_flag_we,
  input  logic              in_wb_en,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_s,
  output logic              flag_z,
  output logic              flag_cy,
  output logic              flag_ov,
  input  logic              flag_load,
  input  logic [3:0]        flag_load_val,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  localparam int ENT_W = ent_width(DATA_W, ADDR_W);

  logic [ENT_W-1:0]  push_ent, head, tail;
  logic [1:0]        occ;
  state_t            state;
  logic              head_vld, head_wb_en, accept, retire;
  logic [FLAG_N-1:0] flags, flags_vis;

  assign push_ent = {in_z, in_cy, in_ov, in_flag_we, in_wb_en, in_dest};
  assign state    = state_t'(occ);

  // Flags an entry would leave behind when it retires on top of cur.
  function automatic logic [FLAG_N-1:0] flag_update(
    input logic [FLAG_N-1:0] cur,
    input logic [ENT_W-1:0]  e
  );
    logic [FLAG_N-1:0] res;
    logic [FLAG_N-1:0] we;
    logic [DATA_W-1:0] z;
    z            = e[ADDR_W+ENT_Z_OFS +: DATA_W];
    we           = e[ADDR_W+ENT_WE_OFS +: FLAG_N];
    res[FLAG_S]  = z[DATA_W-1];
    res[FLAG_Z]  = (z == '0);
    res[FLAG_CY] = e[ADDR_W+ENT_CY_OFS];
    res[FLAG_OV] = e[ADDR_W+ENT_OV_OFS];
    return (res & we) | (cur & ~we);
  endfunction

  fig_06_alu_result_buffer #(.ENT_W(ENT_W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (accept),
    .pop      (retire),
    .push_ent (push_ent),
    .head     (head),
    .tail     (tail),
    .occ      (occ)
  );

  assign head_vld   = (state != EMPTY);
  assign head_wb_en = head[ADDR_W+ENT_WB_EN_OFS];

  // in_ready depends only on registered state and flush, never on wb_ready.
  assign in_ready  = (state != FULL) && !flush;
  assign accept    = in_valid && in_ready;
  assign retire    = head_vld && (!head_wb_en || wb_ready) && !flush;

  assign wb_valid  = head_vld && head_wb_en;
  assign wb_addr   = head[ADDR_W-1:0];
  assign wb_data   = head[ADDR_W+ENT_Z_OFS +: DATA_W];
  assign occupancy = occ;

  // A direct status write overrides whatever the retiring entry would commit.
  always_ff @(posedge clk) begin
    if (rst)
      flags <= '0;
    else if (flag_load)
      flags <= flag_load_val;
    else if (retire)
      flags <= flag_update(flags, head);
  end

`ifdef FIG06_ALU_RESULT_FLAG_FWD_EN
  always_comb begin
    flags_vis = flags;
    if (state != EMPTY) flags_vis = flag_update(flags_vis, head);
    if (state == FULL)  flags_vis = flag_update(flags_vis, tail);
  end
`else
  assign flags_vis = flags;
`endif

  assign flag_s  = flags_vis[FLAG_S];
  assign flag_z  = flags_vis[FLAG_Z];
  assign flag_cy = flags_vis[FLAG_CY];
  assign flag_ov = flags_vis[FLAG_OV];

endmodule

// File: tb/tb_fig_06_alu_result_stage.sv
// Bench for fig_06_alu_result_stage: directed scenarios followed by random
// traffic, all compared against a queue-based model of the result stage.
module tb_fig_06_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_z;
  logic        in_cy, in_ov;
  logic [3:0]  in_flag_we;
  logic        in_wb_en;
  logic [3:0]  in_dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flag_s, flag_z, flag_cy, flag_ov;
  logic        flag_load;
  logic [3:0]  flag_load_val;
  logic        flush;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] z;
    logic        cy;
    logic        ov;
    logic [3:0]  we;
    logic        wb_en;
    logic [3:0]  dest;
  } ent_t;

  ent_t       q[$];
  logic [3:0] mflags;

  always #5 clk = ~clk;

  fig_06_alu_result_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_z          (in_z),
    .in_cy         (in_cy),
    .in_ov         (in_ov),
    .in_flag_we    (in_flag_we),
    .in_wb_en      (in_wb_en),
    .in_dest       (in_dest),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .flag_s        (flag_s),
    .flag_z        (flag_z),
    .flag_cy       (flag_cy),
    .flag_ov       (flag_ov),
    .flag_load     (flag_load),
    .flag_load_val (flag_load_val),
    .flush         (flush),
    .occupancy     (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flag rule: S = sign, Z = zero, CY/OV copied; only enabled bits change.
  function automatic logic [3:0] apply(input logic [3:0] f, input ent_t e);
    logic [3:0] u;
    u = {e.z[15], (e.z == 16'h0), e.cy, e.ov};
    return (u & e.we) | (f & ~e.we);
  endfunction

  function automatic logic [3:0] exp_flags();
    logic [3:0] f;
    f = mflags;
`ifdef FIG06_ALU_RESULT_FLAG_FWD_EN
    foreach (q[i]) f = apply(f, q[i]);
`endif
    return f;
  endfunction

  function automatic logic [3:0] dut_flags();
    return {flag_s, flag_z, flag_cy, flag_ov};
  endfunction

  task automatic model_update();
    ent_t e;
    logic ret, acc;
    int   n;
    if (rst) begin
      q.delete();
      mflags = 4'h0;
      return;
    end
    if (flush) begin
      q.delete();
      if (flag_load) mflags = flag_load_val;
      return;
    end
    n   = q.size();
    ret = (n > 0) && (!q[0].wb_en || wb_ready);
    acc = in_valid && (n < 2);
    if (ret) begin
      mflags = apply(mflags, q[0]);
      q.delete(0);
    end
    if (flag_load) mflags = flag_load_val;
    if (acc) begin
      e.z = in_z; e.cy = in_cy; e.ov = in_ov;
      e.we = in_flag_we; e.wb_en = in_wb_en; e.dest = in_dest;
      q.push_back(e);
    end
  endtask

  // Check outputs mid-cycle against the model, then advance one clock.
  task automatic step();
    logic ewv;
    @(negedge clk);
    ewv = (q.size() > 0) && q[0].wb_en;
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'((q.size() < 2) && !flush));
    check("wb_valid", 32'(wb_valid), 32'(ewv));
    if (ewv) begin
      check("wb_addr", 32'(wb_addr), 32'(q[0].dest));
      check("wb_data", 32'(wb_data), 32'(q[0].z));
    end
    check("flags", 32'(dut_flags()), 32'(exp_flags()));
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] z, input logic cy, input logic ov,
                       input logic [3:0] we, input logic wb_en, input logic [3:0] dest);
    in_valid = 1'b1; in_z = z; in_cy = cy; in_ov = ov;
    in_flag_we = we; in_wb_en = wb_en; in_dest = dest;
  endtask

  initial begin
    logic [15:0] d0;
    logic [3:0]  fsave;
    rst = 1'b1; in_valid = 1'b0; in_z = '0; in_cy = 1'b0; in_ov = 1'b0;
    in_flag_we = '0; in_wb_en = 1'b0; in_dest = '0; wb_ready = 1'b0;
    flag_load = 1'b0; flag_load_val = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    mflags = 4'h0;
    rst = 1'b0;
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_flags", 32'(dut_flags()), 32'd0);

    // Writeback and flags
    wb_ready = 1'b1;
    drive(16'h8000, 1'b1, 1'b1, 4'b1111, 1'b1, 4'h3);
    step();
    in_valid = 1'b0;
    check("t1_wb_valid", 32'(wb_valid), 32'd1);
    check("t1_wb_addr", 32'(wb_addr), 32'd3);
    check("t1_wb_data", 32'(wb_data), 32'h8000);
    step();
    check("t1_flags", 32'(dut_flags()), 32'b1011);

    // Zero result with partial flag enable
    drive(16'h0000, 1'b1, 1'b0, 4'b0110, 1'b1, 4'h5);
    step();
    in_valid = 1'b0;
    step();
    check("t2_flags", 32'(dut_flags()), 32'b1111);

    // Backpressure
    wb_ready = 1'b0;
    drive(16'($urandom), 1'b0, 1'b0, 4'b1111, 1'b1, 4'h1);
    step();
    drive(16'($urandom), 1'b1, 1'b0, 4'b1111, 1'b1, 4'h2);
    step();
    in_valid = 1'b0;
    check("t3_occ_full", 32'(occupancy), 32'd2);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    d0 = wb_data;
    step();
    step();
    check("t3_stall_data", 32'(wb_data), 32'(d0));
    check("t3_stall_addr", 32'(wb_addr), 32'd1);
    wb_ready = 1'b1;
    step();
    check("t3_second_addr", 32'(wb_addr), 32'd2);
    check("t3_second_valid", 32'(wb_valid), 32'd1);
    step();
    check("t3_drained", 32'(occupancy), 32'd0);

    // Compare-type op retires without a writeback, even with wb_ready low
    wb_ready = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 4'b0100, 1'b0, 4'h9);
    step();
    in_valid = 1'b0;
    check("t4_no_wb", 32'(wb_valid), 32'd0);
    check("t4_occ", 32'(occupancy), 32'd1);
    step();
    check("t4_z", 32'(flag_z), 32'd1);
    check("t4_occ_empty", 32'(occupancy), 32'd0);

    // Flag load in the retire cycle wins over the commit
    drive(16'h0000, 1'b1, 1'b1, 4'b1111, 1'b1, 4'h7);
    step();
    in_valid = 1'b0;
    flag_load = 1'b1; flag_load_val = 4'b0001; wb_ready = 1'b1;
    check("t5_wb_valid", 32'(wb_valid), 32'd1);
    check("t5_wb_addr", 32'(wb_addr), 32'd7);
    step();
    flag_load = 1'b0;
    check("t5_flags", 32'(dut_flags()), 32'b0001);
    check("t5_occ", 32'(occupancy), 32'd0);

    // Flush from FULL
    wb_ready = 1'b0;
    drive(16'h1234, 1'b1, 1'b0, 4'b1111, 1'b1, 4'hA);
    step();
    drive(16'hF000, 1'b0, 1'b1, 4'b1111, 1'b1, 4'hB);
    step();
    check("t6_full", 32'(occupancy), 32'd2);
    fsave = mflags;
    flush = 1'b1;
    wb_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t6_occ", 32'(occupancy), 32'd0);
    check("t6_wb_valid", 32'(wb_valid), 32'd0);
    check("t6_flags", 32'(dut_flags()), 32'(fsave));

    // Reset mid-handshake
    wb_ready = 1'b0;
    drive(16'hBEEF, 1'b1, 1'b1, 4'b1111, 1'b1, 4'hC);
    step();
    in_valid = 1'b0;
    check("t7_wb_valid_pre", 32'(wb_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_occ", 32'(occupancy), 32'd0);
    check("t7_wb_valid", 32'(wb_valid), 32'd0);
    check("t7_wb_addr", 32'(wb_addr), 32'd0);
    check("t7_wb_data", 32'(wb_data), 32'd0);
    check("t7_flags", 32'(dut_flags()), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid      = 1'($urandom_range(0, 1));
      in_z          = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      in_cy         = 1'($urandom);
      in_ov         = 1'($urandom);
      in_flag_we    = 4'($urandom);
      in_wb_en      = ($urandom_range(0, 3) != 0);
      in_dest       = 4'($urandom);
      wb_ready      = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 24) == 0);
      flag_load     = ($urandom_range(0, 14) == 0);
      flag_load_val = 4'($urandom);
      rst           = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; flag_load = 1'b0; wb_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fig_06_alu_result_stage.md
Name: fig_06_alu_result_stage

Overview:
- Registered stage directly downstream of the ALU adder/subtractor.
- Captures z, cy and ov from the adder into a 2-entry in-order buffer, then writes z back to the register file over a valid/ready handshake.
- Commits the status flags S, Z, CY and OV when an entry retires, so the flags stay coherent with register-file contents.
- The CY output also feeds back upstream as carry-in for ADC/SBC.

Parameters:
- DATA_W, 16, result width; must match the adder width.
- ADDR_W, 4, register-file destination index width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  adder result presented.
- in_ready  out  1  stage can accept; equals !full && !flush.
- in_z  in  DATA_W  adder result.
- in_cy  in  1  adder carry (unsigned).
- in_ov  in  1  adder overflow (signed).
- in_flag_we  in  4  per-flag update enables; [3]=S, [2]=Z, [1]=CY, [0]=OV.
- in_wb_en  in  1  result is written back (0 for compare-type ops).
- in_dest  in  ADDR_W  destination register index.
- wb_valid  out  1  head entry is requesting writeback.
- wb_ready  in  1  register-file write port accepts.
- wb_addr  out  ADDR_W  head destination.
- wb_data  out  DATA_W  head result.
- flag_s, flag_z, flag_cy, flag_ov  out  1 each  architectural flags.
- flag_load  in  1  direct status-register write.
- flag_load_val  in  4  value for flag_load, same bit order as in_flag_we.
- flush  in  1  discard all pending entries.
- occupancy  out  2  number of entries held (0 to 2).

Behaviour:
- State machine: EMPTY, ONE, FULL. Entry 0 is the head (oldest).
- Reset (sync, rst=1): state EMPTY; occupancy=0; wb_valid=0; wb_addr=0; wb_data=0; all flags 0. Reset mid-handshake drops all entries with no writeback.
- Accept: in_valid && in_ready. The entry stores {in_z, in_cy, in_ov, in_flag_we, in_wb_en, in_dest}.
- Retire: head present && (!head.wb_en || wb_ready).
  - Entries with wb_en=0 retire in the first cycle they are head, with wb_valid=0.
- wb_valid = head present && head.wb_en.
  - Latency: acceptance at edge N gives wb_valid high in cycle N+1.
  - wb_addr and wb_data are driven from registers and held stable while wb_valid && !wb_ready.
- Transitions:
  - EMPTY with accept: go to ONE.
  - ONE with accept and no retire: go to FULL.
  - ONE with retire and no accept: go to EMPTY.
  - ONE with accept and retire together: stay in ONE; the new entry becomes head.
  - FULL with retire: go to ONE; entry 1 shifts to head. There is no accept while FULL.
- On retire, each enabled flag commits:
  - S = head.z[DATA_W-1]
  - Z = (head.z == 0)
  - CY = head.cy
  - OV = head.ov
  - Flags whose enable bit is 0 hold their value.
- flag_load in the same cycle as a retire: flag_load_val wins for all four flags. The entry still retires and its writeback still completes.
- flush: next state EMPTY. No retire, no accept and no flag commit in that cycle. flag_load is still honoured. flush together with rst: rst wins.
- in_ready has a combinational path from flush only. There is no path from wb_ready to in_ready.

Optional Feature:
- Macro: FIG06_ALU_RESULT_FLAG_FWD_EN.
- With the macro defined: flag outputs show the value each flag would have after all held entries retire, i.e. the youngest pending enabled update, else the architectural value. This allows back-to-back ADC without a stall.
- Without the macro: flag outputs are the architectural (retired) flags only.
- flag_load and rst behaviour are identical in both builds.

Decomposition:
- Shared package/include holds:
  - flag bit index localparams: FLAG_S=3, FLAG_Z=2, FLAG_CY=1, FLAG_OV=0;
  - state encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2;
  - the entry field layout (width constants for the packed entry vector).
- One sub-module is natural: fig_06_alu_result_buffer, the 2-entry in-order storage with shift-on-retire. The top level holds the flag evaluation/commit logic and the handshake.

Test Plan:
- Writeback and flags:
  - Stimulus: in_z=16'h8000, cy=1, ov=1, flag_we=4'b1111, wb_en=1, dest=4'h3, wb_ready=1.
  - Response: wb_valid=1 with wb_addr=3 and wb_data=16'h8000 one cycle after accept; after retire S=1, Z=0, CY=1, OV=1.
- Zero result and partial flag enable:
  - Stimulus: in_z=16'h0000, cy=1, flag_we=4'b0110.
  - Response: Z=1, CY=1; S and OV unchanged from the previous test (S=1, OV=1).
- Backpressure:
  - Stimulus: wb_ready=0; accept dest 1 then dest 2.
  - Response: occupancy=2 and in_ready=0.
  - Then: raise wb_ready; dest 1 retires, then dest 2, on consecutive cycles in order; wb_data is stable throughout the stall.
- Compare-type op:
  - Stimulus: wb_en=0, in_z=16'h0000, flag_we=4'b0100.
  - Response: wb_valid is never asserted; Z=1 one cycle after accept; occupancy returns to 0.
- Flag load conflict:
  - Stimulus: flag_load=1 with flag_load_val=4'b0001 in the cycle an entry with z=0 retires.
  - Response: flags S=0, Z=0, CY=0, OV=1; the entry's writeback still occurs.
- Flush and reset:
  - Stimulus: with FULL, assert flush.
  - Response: next cycle occupancy=0, wb_valid=0, flags unchanged.
  - Stimulus: rst while wb_valid=1.
  - Response: next cycle all outputs 0.
